// File: rtl/xor_alu.sv
// Registered bitwise-XOR slice: captures a ^ b with zero/parity status one cycle
// after each accepted operand pair, qualified by out_valid.
module xor_alu #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             out_valid,
    output logic             zero,
    output logic             parity
);

    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] g_next;
    logic             out_valid_reg;
    logic             zero_reg;
    logic             zero_next;
    logic             parity_reg;
    logic             parity_next;
    logic [WIDTH:0]   parity_chain;

    assign parity_chain[0] = 1'b0;

    // Per-bit result and a running XOR chain that yields the parity of the result.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign g_next[gi]         = a[gi] ^ b[gi];
            assign parity_chain[gi+1] = parity_chain[gi] ^ g_next[gi];
        end
    endgenerate

    assign zero_next   = ~|g_next;
    assign parity_next = parity_chain[WIDTH];

    // Result and flags only load on accepted operands, so idle-cycle
    // garbage on a/b never reaches the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_reg         <= '0;
            out_valid_reg <= 1'b0;
            zero_reg      <= 1'b0;
            parity_reg    <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                g_reg      <= g_next;
                zero_reg   <= zero_next;
                parity_reg <= parity_next;
            end
        end
    end

    assign g         = g_reg;
    assign out_valid = out_valid_reg;
    assign zero      = zero_reg;
    assign parity    = parity_reg;

endmodule

// File: tb/tb_xor_alu.sv
// Directed self-checking bench for xor_alu: reset, basic XOR, zero flag, hold,
// asynchronous reset mid-stream and an exhaustive 3-bit sweep.
module tb_xor_alu;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    logic             out_valid;
    logic             zero;
    logic             parity;

    int pass_count;
    int check_count;

    // Observed outputs packed as {out_valid, zero, parity, g}
    logic [WIDTH+2:0] obs;
    assign obs = {out_valid, zero, parity, g};

    xor_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .g         (g),
        .out_valid (out_valid),
        .zero      (zero),
        .parity    (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [WIDTH+2:0] exp_v;
        exp_v    = 6'b000_000;
        rst      = 1'b0;
        a        = 3'b111;
        b        = 3'b000;
        in_valid = 1'b1;
        #1;
        check_count++;
        if (obs !== exp_v)
            $display("FAIL reset_initial: got {ov,z,p,g}=%b expected %b", obs, exp_v);
        else
            pass_count++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_count++;
            $display("reset cycle %0d: {ov,z,p,g}=%b", i, obs);
            if (obs !== exp_v)
                $display("FAIL reset_hold%0d: got {ov,z,p,g}=%b expected %b", i, obs, exp_v);
            else
                pass_count++;
        end
        rst      = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] va [4];
        logic [WIDTH-1:0] vb [4];
        logic [WIDTH+2:0] ve [4];
        va[0] = 3'b001; vb[0] = 3'b011; ve[0] = 6'b101_010;
        va[1] = 3'b101; vb[1] = 3'b001; ve[1] = 6'b101_100;
        va[2] = 3'b010; vb[2] = 3'b110; ve[2] = 6'b101_100;
        va[3] = 3'b100; vb[3] = 3'b001; ve[3] = 6'b100_101;
        for (int i = 0; i < 4; i++) begin
            a        = va[i];
            b        = vb[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_count++;
            $display("basic a=%b b=%b -> {ov,z,p,g}=%b", va[i], vb[i], obs);
            if (obs !== ve[i])
                $display("FAIL basic%0d: got {ov,z,p,g}=%b expected %b", i, obs, ve[i]);
            else
                pass_count++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_zero();
        logic [WIDTH+2:0] exp_v;
        exp_v    = 6'b110_000;
        a        = 3'b111;
        b        = 3'b111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        $display("zero a=111 b=111 -> {ov,z,p,g}=%b", obs);
        if (obs !== exp_v)
            $display("FAIL zero_case: got {ov,z,p,g}=%b expected %b", obs, exp_v);
        else
            pass_count++;
        in_valid = 1'b0;
    endtask

    task automatic test_hold();
        logic [WIDTH+2:0] exp_cap;
        logic [WIDTH+2:0] exp_idle;
        exp_cap  = 6'b100_101;
        exp_idle = 6'b000_101;
        a        = 3'b100;
        b        = 3'b001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        $display("hold capture a=100 b=001 -> {ov,z,p,g}=%b", obs);
        if (obs !== exp_cap)
            $display("FAIL hold_capture: got {ov,z,p,g}=%b expected %b", obs, exp_cap);
        else
            pass_count++;
        in_valid = 1'b0;
        a        = 3'b011;
        b        = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                a = 'x;
                b = 'z;
            end
            @(posedge clk);
            #1;
            check_count++;
            $display("hold idle %0d -> {ov,z,p,g}=%b", i, obs);
            if (obs !== exp_idle)
                $display("FAIL hold_idle%0d: got {ov,z,p,g}=%b expected %b", i, obs, exp_idle);
            else
                pass_count++;
        end
    endtask

    task automatic test_async_reset();
        logic [WIDTH+2:0] exp_first;
        logic [WIDTH+2:0] exp_rst;
        logic [WIDTH+2:0] exp_after;
        exp_first = 6'b101_010;
        exp_rst   = 6'b000_000;
        exp_after = 6'b101_100;
        a        = 3'b001;
        b        = 3'b011;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        $display("stream a=001 b=011 -> {ov,z,p,g}=%b", obs);
        if (obs !== exp_first)
            $display("FAIL async_pre: got {ov,z,p,g}=%b expected %b", obs, exp_first);
        else
            pass_count++;
        a = 3'b101;
        b = 3'b001;
        #2;
        rst = 1'b0;
        #1;
        check_count++;
        $display("async reset between edges -> {ov,z,p,g}=%b", obs);
        if (obs !== exp_rst)
            $display("FAIL async_clear: got {ov,z,p,g}=%b expected %b", obs, exp_rst);
        else
            pass_count++;
        @(posedge clk);
        #1;
        check_count++;
        $display("edge under reset -> {ov,z,p,g}=%b", obs);
        if (obs !== exp_rst)
            $display("FAIL async_discard: got {ov,z,p,g}=%b expected %b", obs, exp_rst);
        else
            pass_count++;
        rst = 1'b1;
        a   = 3'b010;
        b   = 3'b110;
        @(posedge clk);
        #1;
        check_count++;
        $display("after release a=010 b=110 -> {ov,z,p,g}=%b", obs);
        if (obs !== exp_after)
            $display("FAIL async_release: got {ov,z,p,g}=%b expected %b", obs, exp_after);
        else
            pass_count++;
        in_valid = 1'b0;
    endtask

    task automatic test_exhaustive();
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        logic [WIDTH-1:0] eg;
        logic [WIDTH+2:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                ea       = i[WIDTH-1:0];
                eb       = j[WIDTH-1:0];
                a        = ea;
                b        = eb;
                in_valid = 1'b1;
                eg       = ea ^ eb;
                exp_v    = {1'b1, (eg == 3'b000), ($countones(eg) % 2 == 1), eg};
                @(posedge clk);
                #1;
                check_count++;
                $display("sweep a=%b b=%b -> {ov,z,p,g}=%b", ea, eb, obs);
                if (obs !== exp_v)
                    $display("FAIL sweep_%0d_%0d: got {ov,z,p,g}=%b expected %b", i, j, obs, exp_v);
                else
                    pass_count++;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        test_reset();
        test_basic();
        test_zero();
        test_hold();
        test_async_reset();
        test_exhaustive();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
